// File: rtl/spi_fram_responder.sv
// SPI mode-0 slave that emulates a byte-addressed FRAM, with a host backdoor into its memory.
// Define FRAM_STATUS_REG_EN to add RDSR (0x05) and WRSR (0x01).
module spi_fram_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_spi_sck,
    input  logic              i_spi_cs,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [7:0]        i_host_wdata,
    input  logic              i_host_we,
    output logic [7:0]        o_host_rdata,
    output logic              o_wel,
    output logic              o_busy,
    output logic              o_cmd_err
);
    localparam int unsigned Depth = 1 << ADDR_W;
    // Shift register wide enough for the opcode and for the in-range address bits.
    localparam int unsigned ShW   = (ADDR_W > 8) ? ADDR_W : 8;

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StRead, StWrite, StIgnore} state_e;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sck_prev, r_cs_prev;
    logic                   w_sck, w_cs, w_mosi;
    logic                   w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_sck_fall = ~w_sck & r_sck_prev;
    assign w_cs_fall  = ~w_cs & r_cs_prev;
    assign w_cs_rise  = w_cs & ~r_cs_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            r_sck_prev  <= w_sck;
            r_cs_prev   <= w_cs;
        end
    end

    state_e            r_state, w_state_nxt;
    logic [3:0]        r_bit, w_bit_nxt;
    logic [ShW-2:0]    r_shift, w_shift_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [7:0]        r_tx, w_tx_nxt;
    logic              r_miso, w_miso_nxt;
    logic              r_wel, w_wel_nxt;
    logic              r_wrote, w_wrote_nxt;
    logic              r_cmd_err, w_cmd_err_nxt;
    logic              r_is_rd, w_is_rd_nxt;
    logic              r_status, w_status_nxt;
    logic              w_spi_we;
    logic [ShW-1:0]    w_rx;
    logic [7:0]        w_rx_byte;
    logic [ADDR_W-1:0] w_rx_addr, w_addr_inc;
    logic [7:0]        r_mem [Depth];
    logic [7:0]        r_host_rdata;

    assign w_rx       = {r_shift, w_mosi};
    assign w_rx_byte  = w_rx[7:0];
    assign w_rx_addr  = w_rx[ADDR_W-1:0];
    assign w_addr_inc = r_addr + ADDR_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_addr_nxt    = r_addr;
        w_tx_nxt      = r_tx;
        w_miso_nxt    = (r_state == StRead) ? r_miso : 1'b0;
        w_wel_nxt     = r_wel;
        w_wrote_nxt   = r_wrote;
        w_cmd_err_nxt = 1'b0;
        w_is_rd_nxt   = r_is_rd;
        w_status_nxt  = r_status;
        w_spi_we      = 1'b0;
        if (w_cs_rise) begin
            w_state_nxt = StIdle;
            w_miso_nxt  = 1'b0;
            w_wrote_nxt = 1'b0;
            if (r_wrote) w_wel_nxt = 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_cs_fall) begin
                        w_state_nxt  = StCmd;
                        w_bit_nxt    = '0;
                        w_shift_nxt  = '0;
                        w_wrote_nxt  = 1'b0;
                        w_status_nxt = 1'b0;
                    end
                end
                StCmd: begin
                    if (w_sck_rise) begin
                        w_shift_nxt = w_rx[ShW-2:0];
                        w_bit_nxt   = r_bit + 4'd1;
                        if (r_bit == 4'd7) begin
                            w_bit_nxt = '0;
                            case (w_rx_byte)
                                8'h06: begin w_wel_nxt = 1'b1; w_state_nxt = StIgnore; end
                                8'h04: begin w_wel_nxt = 1'b0; w_state_nxt = StIgnore; end
                                8'h03: begin w_is_rd_nxt = 1'b1; w_state_nxt = StAddr; end
                                8'h02: begin w_is_rd_nxt = 1'b0; w_state_nxt = StAddr; end
`ifdef FRAM_STATUS_REG_EN
                                8'h05: begin
                                    w_status_nxt = 1'b1;
                                    w_tx_nxt     = {6'b0, r_wel, 1'b0};
                                    w_state_nxt  = StRead;
                                end
                                8'h01: w_state_nxt = StIgnore;
`endif
                                default: begin w_cmd_err_nxt = 1'b1; w_state_nxt = StIgnore; end
                            endcase
                        end
                    end
                end
                StAddr: begin
                    if (w_sck_rise) begin
                        w_shift_nxt = w_rx[ShW-2:0];
                        w_bit_nxt   = r_bit + 4'd1;
                        if (r_bit == 4'd15) begin
                            w_bit_nxt   = '0;
                            w_addr_nxt  = w_rx_addr;
                            w_tx_nxt    = r_mem[w_rx_addr];
                            w_state_nxt = r_is_rd ? StRead : StWrite;
                        end
                    end
                end
                StRead: begin
                    if (w_sck_fall) begin
                        w_miso_nxt = r_tx[7];
                        w_tx_nxt   = {r_tx[6:0], 1'b0};
                        w_bit_nxt  = r_bit + 4'd1;
                        if (r_bit == 4'd7) begin
                            w_bit_nxt = '0;
                            if (r_status) begin
                                w_tx_nxt = {6'b0, r_wel, 1'b0};
                            end else begin
                                w_addr_nxt = w_addr_inc;
                                w_tx_nxt   = r_mem[w_addr_inc];
                            end
                        end
                    end
                end
                StWrite: begin
                    if (w_sck_rise) begin
                        w_shift_nxt = w_rx[ShW-2:0];
                        w_bit_nxt   = r_bit + 4'd1;
                        if (r_bit == 4'd7) begin
                            w_bit_nxt  = '0;
                            w_addr_nxt = w_addr_inc;
                            if (r_wel) begin
                                w_spi_we    = 1'b1;
                                w_wrote_nxt = 1'b1;
                            end
                        end
                    end
                end
                StIgnore: ;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_bit     <= '0;
            r_shift   <= '0;
            r_addr    <= '0;
            r_tx      <= '0;
            r_miso    <= 1'b0;
            r_wel     <= 1'b0;
            r_wrote   <= 1'b0;
            r_cmd_err <= 1'b0;
            r_is_rd   <= 1'b0;
            r_status  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_addr    <= w_addr_nxt;
            r_tx      <= w_tx_nxt;
            r_miso    <= w_miso_nxt;
            r_wel     <= w_wel_nxt;
            r_wrote   <= w_wrote_nxt;
            r_cmd_err <= w_cmd_err_nxt;
            r_is_rd   <= w_is_rd_nxt;
            r_status  <= w_status_nxt;
        end
    end

    // SPI byte commit has priority; a coinciding host write is dropped.
    always_ff @(posedge clk) begin
        if (w_spi_we) begin
            r_mem[r_addr] <= w_rx_byte;
        end else if (i_host_we) begin
            r_mem[i_host_addr] <= i_host_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_host_rdata <= '0;
        end else begin
            r_host_rdata <= r_mem[i_host_addr];
        end
    end

    assign o_spi_miso   = r_miso;
    assign o_host_rdata = r_host_rdata;
    assign o_wel        = r_wel;
    assign o_busy       = ~w_cs;
    assign o_cmd_err    = r_cmd_err;

endmodule

// File: tb/tb_spi_fram_responder.sv
// Randomized bench for spi_fram_responder: a bit-banged SPI master against a frame-level FRAM model.
// Define FRAM_STATUS_REG_EN to also exercise RDSR/WRSR.
module tb_spi_fram_responder;
    localparam int unsigned AW    = 8;
    localparam int unsigned SS    = 2;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int          HALF  = 6;

    typedef logic [7:0] bq_t [$];

    logic          clk;
    logic          rst_n;
    logic          spi_sck, spi_cs, spi_mosi, spi_miso;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata, host_rdata;
    logic          host_we, wel, busy, cmd_err;

    int         n_checks;
    int         n_errors;
    int         n_err_pulses;
    logic       busy_seen;
    logic [7:0] m_mem [DEPTH];
    logic       m_wel;

    spi_fram_responder #(
        .ADDR_W      (AW),
        .SYNC_STAGES (SS)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_spi_sck    (spi_sck),
        .i_spi_cs     (spi_cs),
        .i_spi_mosi   (spi_mosi),
        .o_spi_miso   (spi_miso),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .i_host_we    (host_we),
        .o_host_rdata (host_rdata),
        .o_wel        (wel),
        .o_busy       (busy),
        .o_cmd_err    (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts high cycles, so a stretched pulse shows up as an extra event.
    always @(negedge clk) if (cmd_err === 1'b1) n_err_pulses++;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input logic [7:0] d);
        host_addr  = AW'(a);
        host_wdata = d;
        host_we    = 1'b1;
        wait_clk(1);
        host_we    = 1'b0;
        m_mem[a]   = d;
    endtask

    task automatic host_read(input int a, output logic [7:0] d);
        host_addr = AW'(a);
        wait_clk(1);
        d = host_rdata;
    endtask

    task automatic host_check(input string tag, input int a);
        logic [7:0] d;
        host_read(a, d);
        check_eq(tag, 32'(d), 32'(m_mem[a]));
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            wait_clk(HALF);
            rx[7-i] = spi_miso;
            spi_sck = 1'b1;
            wait_clk(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic run_frame(input bq_t tx, output bq_t rx);
        logic [7:0] b;
        rx = {};
        spi_cs = 1'b0;
        wait_clk(HALF);
        busy_seen = busy;
        foreach (tx[i]) begin
            wait_clk(int'($urandom_range(0, 8)));
            xfer_bits(tx[i], 8, b);
            rx.push_back(b);
        end
        wait_clk(HALF);
        spi_cs = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // Frame-level FRAM behaviour: expected MISO bytes, cmd_err count, memory and wel updates.
    task automatic model_frame(input bq_t tx, output bq_t exp_rx, output int exp_err);
        int unsigned base;
        bit          wrote;
        exp_rx = {};
        exp_err = 0;
        wrote = 1'b0;
        foreach (tx[i]) exp_rx.push_back(8'h00);
        if (tx.size() == 0) return;
        base = (tx.size() >= 3) ? ({24'b0, tx[1], tx[2]} % DEPTH) : 0;
        case (tx[0])
            8'h06: m_wel = 1'b1;
            8'h04: m_wel = 1'b0;
            8'h03: for (int i = 3; i < tx.size(); i++) exp_rx[i] = m_mem[(base + i - 3) % DEPTH];
            8'h02: begin
                for (int i = 3; i < tx.size(); i++) begin
                    if (m_wel) begin
                        m_mem[(base + i - 3) % DEPTH] = tx[i];
                        wrote = 1'b1;
                    end
                end
                if (wrote) m_wel = 1'b0;
            end
`ifdef FRAM_STATUS_REG_EN
            8'h05: for (int i = 1; i < tx.size(); i++) exp_rx[i] = {6'b0, m_wel, 1'b0};
            8'h01: ;
`endif
            default: exp_err = 1;
        endcase
    endtask

    task automatic do_frame(input string tag, input bq_t tx, output bq_t rx);
        bq_t exp;
        int  exp_err, err0;
        err0 = n_err_pulses;
        model_frame(tx, exp, exp_err);
        run_frame(tx, rx);
        foreach (exp[i]) check_eq($sformatf("%s miso[%0d]", tag, i), 32'(rx[i]), 32'(exp[i]));
        check_eq({tag, " cmd_err"}, 32'(n_err_pulses - err0), 32'(exp_err));
        check_eq({tag, " wel"}, 32'(wel), 32'(m_wel));
    endtask

    initial begin
        bq_t        tx, rx;
        logic [7:0] b, op, old;
        int         sel, nd;

        rst_n = 1'b0; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        host_addr = '0; host_wdata = '0; host_we = 1'b0; m_wel = 1'b0;
        wait_clk(3);
        check_eq("rst miso", 32'(spi_miso), 32'h0);
        check_eq("rst host_rdata", 32'(host_rdata), 32'h0);
        check_eq("rst wel", 32'(wel), 32'h0);
        check_eq("rst busy", 32'(busy), 32'h0);
        check_eq("rst cmd_err", 32'(cmd_err), 32'h0);
        rst_n = 1'b1;
        wait_clk(3);

        for (int a = 0; a < int'(DEPTH); a++) host_write(a, 8'($urandom));

        host_write('h10, 8'hA5);
        host_read('h10, b);
        check_eq("backdoor rd 0x10", 32'(b), 32'hA5);
        tx = {8'h03, 8'h00, 8'h10, 8'h00};
        do_frame("read 0x10", tx, rx);
        check_eq("read 0x10 data", 32'(rx[3]), 32'hA5);
        check_eq("busy in frame", 32'(busy_seen), 32'h1);
        check_eq("busy after frame", 32'(busy), 32'h0);

        tx = {8'h06};
        do_frame("wren", tx, rx);
        check_eq("wel after wren", 32'(wel), 32'h1);
        tx = {8'h02, 8'h00, 8'h20, 8'h3C, 8'hC3};
        do_frame("write 0x20", tx, rx);
        check_eq("wel after write", 32'(wel), 32'h0);
        host_read('h20, b);
        check_eq("mem 0x20", 32'(b), 32'h3C);
        host_read('h21, b);
        check_eq("mem 0x21", 32'(b), 32'hC3);

        old = m_mem['h30];
        tx = {8'h02, 8'h00, 8'h30, 8'h55};
        do_frame("write no wren", tx, rx);
        host_read('h30, b);
        check_eq("mem 0x30 kept", 32'(b), 32'(old));

        tx = {8'h03, 8'h00, 8'hFF, 8'h00, 8'h00};
        do_frame("read wrap", tx, rx);
        tx = {8'h03, 8'h01, 8'h05, 8'h00};
        do_frame("read alias", tx, rx);
        check_eq("alias data", 32'(rx[3]), 32'(m_mem['h05]));

        tx = {8'h9F, 8'hFF, 8'hFF, 8'hFF};
        do_frame("bad op", tx, rx);

        tx = {8'h06};
        do_frame("wren2", tx, rx);
        spi_cs = 1'b0;
        wait_clk(HALF);
        xfer_bits(8'h02, 8, b);
        xfer_bits(8'h00, 8, b);
        xfer_bits(8'h40, 8, b);
        xfer_bits(8'hFF, 4, b);
        wait_clk(HALF);
        spi_cs = 1'b1;
        wait_clk(2 * HALF);
        host_check("partial write 0x40", 'h40);
        check_eq("wel after partial", 32'(wel), 32'(m_wel));
        tx = {8'h04};
        do_frame("wrdi", tx, rx);

        tx = {8'h06};
        do_frame("wren3", tx, rx);
        spi_cs = 1'b0;
        wait_clk(HALF);
        xfer_bits(8'h02, 8, b);
        xfer_bits(8'h00, 8, b);
        xfer_bits(8'h50, 8, b);
        xfer_bits(8'hFF, 3, b);
        rst_n = 1'b0;
        m_wel = 1'b0;
        wait_clk(2);
        check_eq("midrst wel", 32'(wel), 32'h0);
        check_eq("midrst miso", 32'(spi_miso), 32'h0);
        spi_cs = 1'b1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(6);
        host_check("midrst mem 0x50", 'h50);
        tx = {8'h03, 8'h00, 8'h50, 8'h00};
        do_frame("read after rst", tx, rx);

`ifdef FRAM_STATUS_REG_EN
        tx = {8'h06};
        do_frame("sr wren", tx, rx);
        tx = {8'h05, 8'h00, 8'h00};
        do_frame("rdsr wel1", tx, rx);
        check_eq("rdsr 0x02", 32'(rx[1]), 32'h02);
        tx = {8'h04};
        do_frame("sr wrdi", tx, rx);
        tx = {8'h05, 8'h00};
        do_frame("rdsr wel0", tx, rx);
        check_eq("rdsr 0x00", 32'(rx[1]), 32'h00);
        tx = {8'h01, 8'hA5};
        do_frame("wrsr", tx, rx);
`endif

        for (int k = 0; k < 30; k++) begin
            sel = int'($urandom_range(0, 6));
            nd  = int'($urandom_range(1, 3));
            case (sel)
                0, 1:    op = 8'h03;
                2, 3:    op = 8'h02;
                4:       op = 8'h06;
                5:       op = 8'h04;
                default: op = 8'($urandom);
            endcase
            tx = {op};
            if (op == 8'h03 || op == 8'h02) begin
                tx.push_back(8'($urandom));
                tx.push_back(8'($urandom));
            end
            for (int j = 0; j < nd; j++) tx.push_back(8'($urandom));
            do_frame($sformatf("rnd%0d op%02h", k, op), tx, rx);
        end

        for (int a = 0; a < int'(DEPTH); a++) host_check($sformatf("final mem[%0d]", a), a);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
